// File: rtl/intel_pcie_tlp_completer.sv
// intel_pcie_tlp_completer: single-DW MRd/MWr target completer on 256-bit TLP Avalon-ST streams
module intel_pcie_tlp_completer #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       completer_id,
   input  logic [255:0]      tlp_rx_st_data,
   input  logic [2:0]        tlp_rx_st_empty,
   input  logic              tlp_rx_st_startofpacket,
   input  logic              tlp_rx_st_endofpacket,
   input  logic              tlp_rx_st_error,
   input  logic              tlp_rx_st_valid,
   output logic              tlp_rx_st_ready,
   output logic [255:0]      tlp_tx_st_data,
   output logic [2:0]        tlp_tx_st_empty,
   output logic              tlp_tx_st_startofpacket,
   output logic              tlp_tx_st_endofpacket,
   output logic              tlp_tx_st_valid,
   input  logic              tlp_tx_st_ready,
   output logic [ADDR_W-1:0] reg_address,
   output logic              reg_read,
   output logic              reg_write,
   output logic [31:0]       reg_writedata,
   output logic [3:0]        reg_byteenable,
   input  logic              reg_waitrequest,
   input  logic [31:0]       reg_readdata,
   input  logic              reg_readdatavalid,
   output logic [15:0]       drop_count
);
   typedef enum logic [2:0] {IDLE, DROP, WRITE, READ, RDATA, SEND} state_t;
   state_t state_q, state_d;
   logic [31:0] dw0, dw1, dw2, dw3, dw4, lo, pay;
   logic is_mwr, is_mrd, len1, accept, drop_inc, load, build_ur, build_cpl;
   logic rx_ready_q, reg_read_q, reg_write_q, tx_valid_q;
   logic [255:0] tx_data_q, tx_data_d;
   logic [2:0] tx_empty_q, tx_empty_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0] be_q;
   logic [15:0] req_q, req_s, drop_q;
   logic [7:0] tag_q, tag_s;
   logic [2:0] tc_q, tc_s;
   logic [1:0] attr_q, attr_s;
   logic [4:0] la_q, la_s;
   logic unused_ok;
   assign dw0 = tlp_rx_st_data[31:0];
   assign dw1 = tlp_rx_st_data[63:32];
   assign dw2 = tlp_rx_st_data[95:64];
   assign dw3 = tlp_rx_st_data[127:96];
   assign dw4 = tlp_rx_st_data[159:128];
   assign lo = dw0[29] ? dw3 : dw2;
   assign pay = dw0[29] ? dw4 : dw3;
   assign is_mwr = dw0[31:30] == 2'b01 && dw0[28:24] == 5'b0;
   assign is_mrd = dw0[31:30] == 2'b00 && dw0[28:24] == 5'b0;
   assign len1 = dw0[9:0] == 10'd1;
   assign accept = tlp_rx_st_valid && rx_ready_q;
   assign unused_ok = ^{tlp_rx_st_data[255:160], tlp_rx_st_empty, dw0, dw1, lo};
   // Request decode and transaction sequencing
   always_comb begin
      state_d = state_q;
      drop_inc = 1'b0;
      load = 1'b0;
      build_ur = 1'b0;
      build_cpl = 1'b0;
      case (state_q)
         IDLE: if (accept && tlp_rx_st_startofpacket) begin
            if (!tlp_rx_st_endofpacket) begin
               state_d = DROP;
               drop_inc = 1'b1;
            end else if (tlp_rx_st_error) drop_inc = 1'b1;
            else if (is_mwr && len1) begin
               state_d = WRITE;
               load = 1'b1;
            end else if (is_mrd && len1) begin
               state_d = READ;
               load = 1'b1;
            end else if (is_mrd) begin
               state_d = SEND;
               load = 1'b1;
               build_ur = 1'b1;
            end else drop_inc = 1'b1;
         end
         DROP:  if (accept && tlp_rx_st_endofpacket) state_d = IDLE;
         WRITE: if (!reg_waitrequest) state_d = IDLE;
         READ:  if (!reg_waitrequest) state_d = RDATA;
         RDATA: if (reg_readdatavalid) begin
            state_d = SEND;
            build_cpl = 1'b1;
         end
         SEND:  if (tlp_tx_st_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Completion beat assembly; a UR is built straight from the arriving header
   always_comb begin
      req_s = build_ur ? dw1[31:16] : req_q;
      tag_s = build_ur ? dw1[15:8] : tag_q;
      tc_s = build_ur ? dw0[22:20] : tc_q;
      attr_s = build_ur ? dw0[13:12] : attr_q;
      la_s = build_ur ? lo[6:2] : la_q;
      tx_data_d = tx_data_q;
      tx_empty_d = tx_empty_q;
      if (build_ur || build_cpl) begin
         tx_data_d = '0;
         tx_data_d[127:0] = {build_ur ? 32'h0 : reg_readdata,
                             req_s, tag_s, 1'b0, la_s, 2'b00,
                             completer_id, build_ur ? 3'b001 : 3'b000, 1'b0, 12'd4,
                             build_ur ? 3'b000 : 3'b010, 5'b01010, 1'b0, tc_s, 4'b0,
                             2'b00, attr_s, 2'b00, build_ur ? 10'd0 : 10'd1};
         tx_empty_d = build_ur ? 3'd5 : 3'd4;
      end
   end
   // State, registered strobes/beat and request latches
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rx_ready_q <= 1'b0;
         reg_read_q <= 1'b0;
         reg_write_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q <= '0;
         tx_empty_q <= '0;
         drop_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         be_q <= '0;
         req_q <= '0;
         tag_q <= '0;
         tc_q <= '0;
         attr_q <= '0;
         la_q <= '0;
      end else begin
         state_q <= state_d;
         rx_ready_q <= state_d == IDLE || state_d == DROP;
         reg_read_q <= state_d == READ;
         reg_write_q <= state_d == WRITE;
         tx_valid_q <= state_d == SEND;
         tx_data_q <= tx_data_d;
         tx_empty_q <= tx_empty_d;
         if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         if (load) begin
            addr_q <= lo[ADDR_W+1:2];
            wdata_q <= pay;
            be_q <= dw1[3:0];
            req_q <= dw1[31:16];
            tag_q <= dw1[15:8];
            tc_q <= dw0[22:20];
            attr_q <= dw0[13:12];
            la_q <= lo[6:2];
         end
      end
   end
   assign tlp_rx_st_ready = rx_ready_q;
   assign tlp_tx_st_data = tx_data_q;
   assign tlp_tx_st_empty = tx_empty_q;
   assign tlp_tx_st_valid = tx_valid_q;
   assign tlp_tx_st_startofpacket = tx_valid_q;
   assign tlp_tx_st_endofpacket = tx_valid_q;
   assign reg_read = reg_read_q;
   assign reg_write = reg_write_q;
   assign reg_address = addr_q;
   assign reg_writedata = wdata_q;
   assign reg_byteenable = be_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_intel_pcie_tlp_completer.sv
// tb_intel_pcie_tlp_completer: directed bench with a completion scoreboard
module tb_intel_pcie_tlp_completer;
   localparam logic [15:0] CID = 16'h0300;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [15:0] completer_id = CID;
   logic [255:0] tlp_rx_st_data = '0;
   logic [2:0] tlp_rx_st_empty = '0;
   logic tlp_rx_st_startofpacket = 1'b0, tlp_rx_st_endofpacket = 1'b0;
   logic tlp_rx_st_error = 1'b0, tlp_rx_st_valid = 1'b0, tlp_rx_st_ready;
   logic [255:0] tlp_tx_st_data;
   logic [2:0] tlp_tx_st_empty;
   logic tlp_tx_st_startofpacket, tlp_tx_st_endofpacket, tlp_tx_st_valid;
   logic tlp_tx_st_ready = 1'b1;
   logic [9:0] reg_address;
   logic reg_read, reg_write;
   logic [31:0] reg_writedata;
   logic [3:0] reg_byteenable;
   logic reg_waitrequest = 1'b0;
   logic [31:0] reg_readdata = '0;
   logic reg_readdatavalid = 1'b0;
   logic [15:0] drop_count;
   int checks = 0, failures = 0;
   typedef struct {logic [255:0] d; logic [2:0] e;} exp_t;
   exp_t exp_q[$];
   exp_t cur;
   localparam logic [255:0] CPL1 = {128'h0, 32'hDEADBEEF, 32'h01002A10, 32'h03000004, 32'h4A000001};
   localparam logic [255:0] UR1  = {128'h0, 32'h00000000, 32'h02001144, 32'h03002004, 32'h0A000000};
   localparam logic [255:0] CPL2 = {128'h0, 32'hCAFEF00D, 32'h1234557C, 32'h03000004, 32'h4A000001};
   localparam logic [255:0] CPL3 = {128'h0, 32'h0BADCAFE, 32'h00016608, 32'h03000004, 32'h4A302001};

   intel_pcie_tlp_completer #(.ADDR_W(10)) dut (
      .clk(clk), .reset_n(reset_n), .completer_id(completer_id),
      .tlp_rx_st_data(tlp_rx_st_data), .tlp_rx_st_empty(tlp_rx_st_empty),
      .tlp_rx_st_startofpacket(tlp_rx_st_startofpacket), .tlp_rx_st_endofpacket(tlp_rx_st_endofpacket),
      .tlp_rx_st_error(tlp_rx_st_error), .tlp_rx_st_valid(tlp_rx_st_valid), .tlp_rx_st_ready(tlp_rx_st_ready),
      .tlp_tx_st_data(tlp_tx_st_data), .tlp_tx_st_empty(tlp_tx_st_empty),
      .tlp_tx_st_startofpacket(tlp_tx_st_startofpacket), .tlp_tx_st_endofpacket(tlp_tx_st_endofpacket),
      .tlp_tx_st_valid(tlp_tx_st_valid), .tlp_tx_st_ready(tlp_tx_st_ready),
      .reg_address(reg_address), .reg_read(reg_read), .reg_write(reg_write),
      .reg_writedata(reg_writedata), .reg_byteenable(reg_byteenable),
      .reg_waitrequest(reg_waitrequest), .reg_readdata(reg_readdata),
      .reg_readdatavalid(reg_readdatavalid), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mrd3(input logic [31:0] a, input logic [7:0] tag, input logic [15:0] req,
                                        input logic [9:0] len, input logic [2:0] tc, input logic [1:0] attr);
      logic [255:0] t = '0;
      t[31:0] = {3'b000, 5'b0, 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len};
      t[63:32] = {req, tag, 8'h0F};
      t[95:64] = a;
      return t;
   endfunction

   function automatic logic [255:0] mwr4(input logic [63:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [255:0] t = '0;
      t[31:0] = {3'b011, 5'b0, 14'b0, 10'd1};
      t[63:32] = {16'h0100, 8'h05, 4'h0, be};
      t[95:64] = a[63:32];
      t[127:96] = a[31:0];
      t[159:128] = d;
      return t;
   endfunction

   task automatic rx_beat(input logic [255:0] d, input logic s, input logic e, input logic er);
      int n = 0;
      while (!tlp_rx_st_ready && n < 50) begin
         step();
         n++;
      end
      chk("rx_ready_wait", tlp_rx_st_ready, 1'b1);
      tlp_rx_st_data = d;
      tlp_rx_st_startofpacket = s;
      tlp_rx_st_endofpacket = e;
      tlp_rx_st_error = er;
      tlp_rx_st_valid = 1'b1;
      step();
      tlp_rx_st_valid = 1'b0;
      tlp_rx_st_error = 1'b0;
   endtask

   // Completion scoreboard: every tx handshake must match the oldest pending expectation
   always @(negedge clk) begin
      if (reset_n && tlp_tx_st_valid && tlp_tx_st_ready) begin
         if (exp_q.size() == 0) chk("tx_unexpected", tlp_tx_st_valid, 1'b0);
         else begin
            cur = exp_q.pop_front();
            chk("tx_data", tlp_tx_st_data, cur.d);
            chk("tx_empty", tlp_tx_st_empty, cur.e);
            chk("tx_sop_eop", {tlp_tx_st_startofpacket, tlp_tx_st_endofpacket}, 2'b11);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rx_ready", tlp_rx_st_ready, 1'b0);
      chk("rst_tx_valid", tlp_tx_st_valid, 1'b0);
      chk("rst_strobes", {reg_read, reg_write}, 2'b00);
      chk("rst_drop", drop_count, 16'h0);
      reset_n = 1'b1;
      step();
      chk("post_rst_ready", tlp_rx_st_ready, 1'b1);

      // MRd 3DW, two waitrequest cycles
      exp_q.push_back('{CPL1, 3'd4});
      reg_waitrequest = 1'b1;
      rx_beat(mrd3(32'h10, 8'h2A, 16'h0100, 10'd1, 3'd0, 2'd0), 1'b1, 1'b1, 1'b0);
      chk("mrd_read", reg_read, 1'b1);
      chk("mrd_addr", reg_address, 10'd4);
      chk("mrd_ready_low", tlp_rx_st_ready, 1'b0);
      step();
      chk("mrd_read_held", reg_read, 1'b1);
      reg_waitrequest = 1'b0;
      step();
      chk("mrd_read_drop", reg_read, 1'b0);
      reg_readdata = 32'hDEADBEEF;
      reg_readdatavalid = 1'b1;
      step();
      reg_readdatavalid = 1'b0;
      reg_readdata = 32'h0;
      chk("cpld_valid", tlp_tx_st_valid, 1'b1);
      step();
      chk("cpld_done", tlp_tx_st_valid, 1'b0);
      chk("cpld_ready_back", tlp_rx_st_ready, 1'b1);

      // MWr 4DW
      reg_waitrequest = 1'b1;
      rx_beat(mwr4(64'h1_0000_0020, 4'h3, 32'h12345678), 1'b1, 1'b1, 1'b0);
      chk("mwr_write", {reg_write, reg_read}, 2'b10);
      chk("mwr_addr", reg_address, 10'd8);
      chk("mwr_be", reg_byteenable, 4'h3);
      chk("mwr_data", reg_writedata, 32'h12345678);
      step();
      chk("mwr_write_held", reg_write, 1'b1);
      chk("mwr_ready_low", tlp_rx_st_ready, 1'b0);
      reg_waitrequest = 1'b0;
      step();
      chk("mwr_write_drop", reg_write, 1'b0);
      chk("mwr_ready_back", tlp_rx_st_ready, 1'b1);
      chk("mwr_no_tx", tlp_tx_st_valid, 1'b0);

      // MRd length 2 -> UR
      exp_q.push_back('{UR1, 3'd5});
      rx_beat(mrd3(32'h44, 8'h11, 16'h0200, 10'd2, 3'd0, 2'd0), 1'b1, 1'b1, 1'b0);
      chk("ur_valid", tlp_tx_st_valid, 1'b1);
      chk("ur_no_read", reg_read, 1'b0);
      chk("ur_empty", tlp_tx_st_empty, 3'd5);
      step();
      chk("ur_ready_back", tlp_rx_st_ready, 1'b1);

      // Discards: multi-beat, error-flagged, Cfg, then a stray non-SOP beat
      rx_beat(256'hA5, 1'b1, 1'b0, 1'b0);
      chk("drop_ready1", tlp_rx_st_ready, 1'b1);
      rx_beat(256'h5A, 1'b0, 1'b0, 1'b0);
      chk("drop_ready2", tlp_rx_st_ready, 1'b1);
      rx_beat(256'h3C, 1'b0, 1'b1, 1'b0);
      chk("drop_ready3", tlp_rx_st_ready, 1'b1);
      chk("drop_cnt1", drop_count, 16'd1);
      rx_beat(mrd3(32'h10, 8'h01, 16'h0100, 10'd1, 3'd0, 2'd0), 1'b1, 1'b1, 1'b1);
      chk("drop_ready4", tlp_rx_st_ready, 1'b1);
      rx_beat({224'h0, 32'h04000001}, 1'b1, 1'b1, 1'b0);
      chk("drop_ready5", tlp_rx_st_ready, 1'b1);
      rx_beat(mrd3(32'h10, 8'h02, 16'h0100, 10'd1, 3'd0, 2'd0), 1'b0, 1'b1, 1'b0);
      chk("drop_cnt3", drop_count, 16'd3);
      chk("drop_no_reg", {reg_read, reg_write}, 2'b00);
      chk("drop_no_tx", tlp_tx_st_valid, 1'b0);
      chk("drop_ready6", tlp_rx_st_ready, 1'b1);

      // Backpressure on SEND with the next MRd already presented
      tlp_tx_st_ready = 1'b0;
      exp_q.push_back('{CPL2, 3'd4});
      exp_q.push_back('{CPL3, 3'd4});
      rx_beat(mrd3(32'h7C, 8'h55, 16'h1234, 10'd1, 3'd0, 2'd0), 1'b1, 1'b1, 1'b0);
      chk("bp_read", reg_read, 1'b1);
      step();
      reg_readdata = 32'hCAFEF00D;
      reg_readdatavalid = 1'b1;
      step();
      reg_readdata = 32'hFFFFFFFF;
      tlp_rx_st_data = mrd3(32'h08, 8'h66, 16'h0001, 10'd1, 3'd3, 2'd2);
      tlp_rx_st_startofpacket = 1'b1;
      tlp_rx_st_endofpacket = 1'b1;
      tlp_rx_st_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", tlp_tx_st_valid, 1'b1);
         chk("bp_data_held", tlp_tx_st_data, CPL2);
         chk("bp_rx_blocked", tlp_rx_st_ready, 1'b0);
         step();
      end
      reg_readdatavalid = 1'b0;
      tlp_tx_st_ready = 1'b1;
      chk("bp_rx_blocked_hs", tlp_rx_st_ready, 1'b0);
      step();
      chk("bp_hs_done", tlp_tx_st_valid, 1'b0);
      chk("bp_ready_back", tlp_rx_st_ready, 1'b1);
      step();
      tlp_rx_st_valid = 1'b0;
      chk("bp2_read", reg_read, 1'b1);
      chk("bp2_addr", reg_address, 10'd2);
      step();
      reg_readdata = 32'h0BADCAFE;
      reg_readdatavalid = 1'b1;
      step();
      reg_readdatavalid = 1'b0;
      chk("bp2_valid", tlp_tx_st_valid, 1'b1);
      step();
      chk("bp2_ready_back", tlp_rx_st_ready, 1'b1);

      // Reset while waiting for read data
      rx_beat(mrd3(32'h20, 8'h77, 16'h0100, 10'd1, 3'd0, 2'd0), 1'b1, 1'b1, 1'b0);
      step();
      reset_n = 1'b0;
      #1;
      chk("arst_rx_ready", tlp_rx_st_ready, 1'b0);
      chk("arst_strobes", {reg_read, reg_write}, 2'b00);
      chk("arst_tx_valid", tlp_tx_st_valid, 1'b0);
      chk("arst_tx_data", tlp_tx_st_data, 256'h0);
      chk("arst_addr", reg_address, 10'd0);
      chk("arst_drop", drop_count, 16'd0);
      step();
      chk("arst_ready_held", tlp_rx_st_ready, 1'b0);
      reset_n = 1'b1;
      step();
      chk("arst_ready_back", tlp_rx_st_ready, 1'b1);
      reg_readdata = 32'h11111111;
      reg_readdatavalid = 1'b1;
      step();
      reg_readdatavalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("arst_no_tx", tlp_tx_st_valid, 1'b0);
         step();
      end
      chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/intel_pcie_tlp_completer.md
# intel_pcie_tlp_completer

Single-DW target completer on the 256-bit TLP-side Avalon-ST streams of the PCIe adapter. It consumes request TLPs from `tlp_rx_st`, performs 32-bit accesses on an Avalon-MM register port, and sources completion TLPs on `tlp_tx_st`. It is the responder to host-initiated MRd/MWr traffic, with one transaction in flight at a time.

## Interface
- `ADDR_W`, 10: register port dword-address width; request address bits [ADDR_W+1:2] are used, upper bits ignored.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `completer_id`  in  16  bus/dev/fn placed in CplD DW1[31:16].
- `tlp_rx_st_data`  in  256  request TLP; header DW0 at [31:0], then DW1, DW2, (DW3); payload DW immediately after the header.
- `tlp_rx_st_empty`  in  3  empty dwords in the final beat (ignored).
- `tlp_rx_st_startofpacket` / `tlp_rx_st_endofpacket` / `tlp_rx_st_error` / `tlp_rx_st_valid`  in  1 each.
- `tlp_rx_st_ready`  out  1.
- `tlp_tx_st_data`  out  256  completion TLP, same packing.
- `tlp_tx_st_empty`  out  3  empty dwords.
- `tlp_tx_st_startofpacket` / `tlp_tx_st_endofpacket` / `tlp_tx_st_valid`  out  1 each.
- `tlp_tx_st_ready`  in  1.
- `reg_address`  out  ADDR_W;  `reg_read` / `reg_write`  out  1;  `reg_writedata`  out  32;  `reg_byteenable`  out  4 (first BE).
- `reg_waitrequest`  in  1;  `reg_readdata`  in  32;  `reg_readdatavalid`  in  1.
- `drop_count`  out  16  saturating count of discarded TLPs.

## Operation
- FSM states: IDLE, DROP, WRITE, READ, RDATA, SEND.
- `tlp_rx_st_ready` = 1 only in IDLE and DROP. A beat is accepted when valid & ready.
- IDLE, accepted beat with SOP:
  - SOP & EOP, no error, MWr (fmt 010/011, type 00000), length 1 -> WRITE. The beat supplies address, first BE and payload DW.
  - SOP & EOP, no error, MRd (fmt 000/001, type 00000), length 1 -> READ. The beat latches requester ID, tag, TC, attr and addr[6:2].
  - MRd with length != 1, no error -> SEND with UR completion.
  - Any other type, or error set -> discard, `drop_count`+1.
  - Beat without EOP -> DROP, `drop_count`+1.
- Beat without SOP in IDLE -> discard, no count.
- DROP: consume beats until an accepted EOP, then IDLE.
- WRITE: hold `reg_write` with address/data/BE until `reg_waitrequest`=0, then IDLE. MWr gets no completion.
- READ: hold `reg_read` until `reg_waitrequest`=0, then RDATA.
- RDATA: wait for `reg_readdatavalid`, latch `reg_readdata`, then SEND.
- SEND: hold the beat stable with valid=SOP=EOP=1 until `tlp_tx_st_ready`=1, then IDLE.
- CplD: 3DW header plus payload at [127:96], empty=4.
  - DW0: fmt 010, type 01010, length 1, latched TC/attr.
  - DW1: completer_id, status 000, BCM 0, byte count 4.
  - DW2: requester ID, tag, lower address {addr[6:2],2'b00}.
- UR Cpl: fmt 000, type 01010, length 0, status 001, byte count 4, empty=5, payload dwords zero.
- All unused tx data bits are 0.
- `drop_count` saturates at 16'hFFFF.

## Timing
- Reset (reset_n=0, async):
  - state=IDLE.
  - `tlp_rx_st_ready`=0 while reset is asserted; it goes to 1 on the first clock edge after release.
  - All tx outputs, `reg_read`, `reg_write`, and reg data/address/BE are 0.
  - `drop_count`=0.
- Reset mid-transaction aborts it: no completion, strobes drop immediately.
- The MRd/MWr accept edge is cycle N:
  - `reg_read` or `reg_write` is asserted from cycle N+1.
  - `tlp_rx_st_ready` is 0 from N+1.
- `reg_readdatavalid` in cycle M -> `tlp_tx_st_valid` from M+1.
- UR: `tlp_tx_st_valid` from N+1.
- tx handshake completes on the edge with valid & ready. `tlp_rx_st_ready` returns to 1 in the following cycle, so back-to-back MRd throughput is at most one per 4 cycles.
- Strobes and tx beat are registered outputs, with no combinational path from rx or reg inputs to them.
- `reg_readdatavalid` outside RDATA is ignored.

## Test plan
- MRd 3DW, addr 0x0000_0010, tag 0x2A, req ID 0x0100; readdata 0xDEADBEEF after 2 waitrequest cycles:
  - `reg_address`=4.
  - CplD DW0=0x4A000001, DW1={completer_id,16'h0004}, DW2=0x01002A10, DW3=0xDEADBEEF, empty=4.
- MWr 4DW, addr 0x1_0000_0020, FBE 0x3, data 0x12345678:
  - `reg_write` with address 8, BE 0x3.
  - No tx beat.
  - Ready returns 1 cycle after waitrequest drops.
- MRd length 2 -> UR Cpl with DW0=0x0A000000, DW1 status 001, empty=5; no `reg_read`.
- 3-beat packet, then an error-flagged single beat, then a Cfg request:
  - `drop_count`=3.
  - Ready stays 1 throughout.
  - No reg or tx activity.
- Backpressure: `tlp_tx_st_ready`=0 for 5 cycles during SEND -> beat held unchanged; a next MRd on rx is not accepted until 1 cycle after the handshake.
- Assert reset_n=0 in RDATA:
  - All outputs reset asynchronously.
  - A late `reg_readdatavalid` after release produces no tx beat.
